clkfreq_check: RTL and testbench
================================

CLKFREQ_CHECK -- requirements
Module: clkfreq_check

Interface
REQ-001 SHALL have parameter BUSW, default 32, width of count and threshold words.
REQ-002 SHALL have parameter NGOOD, default 4, consecutive in-range samples (1-15) required to lock.
REQ-003 SHALL have parameter NBAD, default 2, consecutive out-of-range samples (1-15) required to drop lock.
REQ-004 SHALL have parameter TIMEOUT, default 200_000_000, sys-clock cycles without a sample before fault; 0 disables.
REQ-005 SHALL have port i_sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_valid  in  1  one-cycle strobe: i_counts holds a new once-per-second measurement.
REQ-008 SHALL have port i_counts  in  BUSW  measured tick count of the monitored clock.
REQ-009 SHALL have ports i_min, i_max  in  BUSW each  inclusive unsigned acceptance window.
REQ-010 SHALL have port i_clear  in  1  clears sticky fault and extreme trackers.
REQ-011 SHALL have port o_state  out  2  0 IDLE, 1 LOCKING, 2 LOCKED, 3 FAULT.
REQ-012 SHALL have ports o_locked, o_fault_seen, o_int  out  1 each  state==LOCKED; sticky fault; state-change pulse.
REQ-013 SHALL have ports o_last, o_min_seen, o_max_seen  out  BUSW each  last sample; smallest/largest since clear.

Function
REQ-014 SHALL classify a sample as DEAD if i_counts==0, IN if i_min<=i_counts<=i_max (unsigned), else OUT; i_min>i_max makes every nonzero sample OUT.
REQ-015 SHALL register all outputs; a sample accepted at edge N is reflected on every output after edge N+1 (one-cycle latency).
REQ-016 SHALL ignore i_counts/i_min/i_max on cycles with i_valid low.
REQ-017 SHALL keep good counter g and bad counter b, each 4 bits, saturating, never wrapping.
REQ-018 SHALL, in IDLE on a sample, enter LOCKING and process that sample as in LOCKING.
REQ-019 SHALL, in LOCKING: IN increments g, entering LOCKED with b=0 when g reaches NGOOD; OUT clears g.
REQ-020 SHALL, in LOCKED: IN clears b; OUT increments b, entering FAULT when b reaches NBAD.
REQ-021 SHALL, in FAULT: IN enters LOCKING with g=1 (direct to LOCKED if NGOOD==1); OUT stays FAULT.
REQ-022 SHALL, on DEAD in any state, enter FAULT immediately, overriding REQ-018..021.
REQ-023 SHALL count cycles since last i_valid outside IDLE; at TIMEOUT consecutive such cycles, enter FAULT and restart the count; i_valid on the expiry cycle takes precedence over timeout.
REQ-024 SHALL clear g and b on every state change.
REQ-025 SHALL pulse o_int high exactly one cycle per state change, including FAULT->FAULT re-entry from timeout or DEAD being excluded (no pulse when state unchanged).
REQ-026 SHALL set o_fault_seen on any entry into FAULT; i_clear clears it; simultaneous set and clear leaves it set.
REQ-027 SHALL update o_last on every sample; o_min_seen/o_max_seen track extremes over samples including DEAD.
REQ-028 SHALL, on i_clear, set o_min_seen to all-ones and o_max_seen to 0; i_clear with i_valid loads both with the sample.
REQ-029 SHALL not let i_clear affect o_state, g, b, or the timeout counter.

Reset
REQ-030 SHALL, on i_reset asserted asynchronously, force o_state=IDLE, g=b=0, timeout counter 0, o_locked=o_fault_seen=o_int=0, o_last=0, o_min_seen=all-ones, o_max_seen=0.
REQ-031 SHALL, on reset mid-operation, discard any sample presented that cycle and resume from IDLE after deassertion.

Verification
REQ-032 SHALL verify: window 99_000_000..101_000_000, four IN samples of 100_000_000 -> o_state 1,1,1,2, one o_int at IDLE->LOCKING and one at LOCKING->LOCKED.
REQ-033 SHALL verify: LOCKED, samples 102_000_000, 100_000_000, 102_000_000, 102_000_000 -> stays LOCKED until 4th, then FAULT, o_fault_seen=1.
REQ-034 SHALL verify: LOCKED, sample 0 -> FAULT next cycle; then IN sample -> LOCKING with g=1, o_fault_seen remains 1 until i_clear.
REQ-035 SHALL verify: TIMEOUT=10, LOCKED, no i_valid for 10 cycles -> FAULT on 10th; i_valid on 10th cycle instead -> no timeout.
REQ-036 SHALL verify: i_clear with i_valid and sample 5 -> o_min_seen=o_max_seen=5; i_clear with fault entry same cycle -> o_fault_seen=1.
REQ-037 SHALL verify: i_reset pulsed mid-LOCKING with i_valid high -> all outputs at reset values, sample not recorded.

Source files
------------

// File: rtl/clkfreq_check_if.sv
// clkfreq_check_if: sample/window inputs and lock/fault status outputs of clkfreq_check
interface clkfreq_check_if #(parameter int unsigned BUSW = 32);
    logic            i_valid;
    logic [BUSW-1:0] i_counts;
    logic [BUSW-1:0] i_min;
    logic [BUSW-1:0] i_max;
    logic            i_clear;
    logic [1:0]      o_state;
    logic            o_locked;
    logic            o_fault_seen;
    logic            o_int;
    logic [BUSW-1:0] o_last;
    logic [BUSW-1:0] o_min_seen;
    logic [BUSW-1:0] o_max_seen;
    modport master (
        output i_valid, i_counts, i_min, i_max, i_clear,
        input  o_state, o_locked, o_fault_seen, o_int, o_last, o_min_seen, o_max_seen
    );
    modport slave (
        input  i_valid, i_counts, i_min, i_max, i_clear,
        output o_state, o_locked, o_fault_seen, o_int, o_last, o_min_seen, o_max_seen
    );
endinterface

// File: rtl/clkfreq_check.sv
// clkfreq_check: classifies once-per-second clock counts against a window and tracks lock/fault
module clkfreq_check #(
    parameter int unsigned BUSW    = 32,
    parameter int unsigned NGOOD   = 4,
    parameter int unsigned NBAD    = 2,
    parameter int unsigned TIMEOUT = 200_000_000
) (
    input logic              i_sys_clk,
    input logic              i_reset,
    clkfreq_check_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2, FAULT = 2'd3;
    localparam logic [3:0] NG = 4'(NGOOD), NB = 4'(NBAD);

    logic [1:0]      state_q, state_d;
    logic [3:0]      g_q, g_d, b_q, b_d, g_inc, b_inc;
    logic [31:0]     tmo_q, tmo_d;
    logic            locked_q, locked_d, fault_q, fault_d, int_q, int_d;
    logic [BUSW-1:0] last_q, last_d, min_q, min_d, max_q, max_d;
    logic            dead, in_win, out_win, tmo_hit;

    // Sample classification and timeout expiry; a sample on the expiry cycle wins
    always_comb begin
        dead    = bus.i_valid && bus.i_counts == '0;
        in_win  = bus.i_valid && !dead && bus.i_min <= bus.i_counts && bus.i_counts <= bus.i_max;
        out_win = bus.i_valid && !dead && !in_win;
        tmo_hit = TIMEOUT != 0 && state_q != IDLE && !bus.i_valid && tmo_q + 32'd1 == TIMEOUT;
    end

    // Lock state machine; g is always 0 in IDLE/FAULT so those share the LOCKING increment path
    always_comb begin
        g_inc   = (g_q == 4'hf) ? g_q : g_q + 4'd1;
        b_inc   = (b_q == 4'hf) ? b_q : b_q + 4'd1;
        state_d = state_q;
        g_d     = g_q;
        b_d     = b_q;
        if (dead || tmo_hit) begin
            state_d = FAULT;
        end else if (in_win) begin
            if (state_q == LOCKED) begin
                b_d = 4'd0;
            end else begin
                g_d     = g_inc;
                state_d = (g_inc >= NG) ? LOCKED : LOCKING;
            end
        end else if (out_win) begin
            if (state_q == LOCKED) begin
                b_d     = b_inc;
                state_d = (b_inc >= NB) ? FAULT : LOCKED;
            end else if (state_q != FAULT) begin
                g_d     = 4'd0;
                state_d = LOCKING;
            end
        end
        if (state_d != state_q) begin
            b_d = 4'd0;
            g_d = (state_d == LOCKING) ? g_d : 4'd0;
        end
        tmo_d    = (state_q == IDLE || bus.i_valid || tmo_hit || TIMEOUT == 0) ? 32'd0 : tmo_q + 32'd1;
        int_d    = state_d != state_q;
        locked_d = state_d == LOCKED;
        fault_d  = dead || tmo_hit || (state_d == FAULT && state_q != FAULT) || (fault_q && !bus.i_clear);
    end

    // Sample history: last value and extremes, with clear reloading from the concurrent sample
    always_comb begin
        last_d = bus.i_valid ? bus.i_counts : last_q;
        min_d  = bus.i_clear ? (bus.i_valid ? bus.i_counts : '1)
               : (bus.i_valid && bus.i_counts < min_q) ? bus.i_counts : min_q;
        max_d  = bus.i_clear ? (bus.i_valid ? bus.i_counts : '0)
               : (bus.i_valid && bus.i_counts > max_q) ? bus.i_counts : max_q;
    end

    // State and output registers
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            g_q      <= 4'd0;
            b_q      <= 4'd0;
            tmo_q    <= 32'd0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            int_q    <= 1'b0;
            last_q   <= '0;
            min_q    <= '1;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            b_q      <= b_d;
            tmo_q    <= tmo_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            int_q    <= int_d;
            last_q   <= last_d;
            min_q    <= min_d;
            max_q    <= max_d;
        end
    end

    assign bus.o_state      = state_q;
    assign bus.o_locked     = locked_q;
    assign bus.o_fault_seen = fault_q;
    assign bus.o_int        = int_q;
    assign bus.o_last       = last_q;
    assign bus.o_min_seen   = min_q;
    assign bus.o_max_seen   = max_q;
endmodule

// File: tb/tb_clkfreq_check.sv
// tb_clkfreq_check: directed scoreboard bench for clkfreq_check (TIMEOUT=10, NGOOD=4, NBAD=2)
module tb_clkfreq_check;
    localparam logic [31:0] A = 32'd100_000_000, H = 32'd102_000_000, ONES = 32'hffff_ffff;

    typedef struct {
        int          tag;
        logic [1:0]  st;
        logic        it;
        logic        fl;
        logic        cx;
        logic [31:0] la;
        logic [31:0] mn;
        logic [31:0] mx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   tag = 0;

    clkfreq_check_if #(.BUSW(32)) bus ();

    clkfreq_check #(.BUSW(32), .NGOOD(4), .NBAD(2), .TIMEOUT(10)) dut (
        .i_sys_clk (clk),
        .i_reset   (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cmp(input int t, input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL step%0d %s got=%0h want=%0h", t, nm, got, want);
        end
    endtask

    // Monitor: one expectation per cycle, sampled 1 time unit after the active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp(e.tag, "state", {30'd0, bus.o_state}, {30'd0, e.st});
                cmp(e.tag, "locked", {31'd0, bus.o_locked}, {31'd0, e.st == 2'd2});
                cmp(e.tag, "int", {31'd0, bus.o_int}, {31'd0, e.it});
                cmp(e.tag, "fault_seen", {31'd0, bus.o_fault_seen}, {31'd0, e.fl});
                if (e.cx) begin
                    cmp(e.tag, "last", bus.o_last, e.la);
                    cmp(e.tag, "min_seen", bus.o_min_seen, e.mn);
                    cmp(e.tag, "max_seen", bus.o_max_seen, e.mx);
                end
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [31:0] c, input logic clr,
                        input logic [1:0] st, input logic it, input logic fl,
                        input logic cx, input logic [31:0] la, input logic [31:0] mn, input logic [31:0] mx);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.i_valid = v;
        bus.i_counts = c;
        bus.i_clear = clr;
        tag++;
        e = '{tag, st, it, fl, cx, la, mn, mx};
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [1:0] st, input logic fl);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, st, 0, fl, 0, 0, 0, 0);
    endtask

    initial begin
        bus.i_valid = 0;
        bus.i_counts = 0;
        bus.i_clear = 0;
        bus.i_min = 32'd99_000_000;
        bus.i_max = 32'd101_000_000;
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, ONES, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, ONES, 0);
        // four in-window samples lock
        step(0, 1, A, 0, 1, 1, 0, 1, A, A, A);
        step(0, 1, A, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, A, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, A, 0, 2, 1, 0, 0, 0, 0, 0);
        // bad counter reset by an in-window sample, then two consecutive bad samples fault
        step(0, 1, H, 0, 2, 0, 0, 1, H, A, H);
        step(0, 1, A, 0, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, H, 0, 2, 0, 0, 0, 0, 0, 0);
        step(0, 1, H, 0, 3, 1, 1, 0, 0, 0, 0);
        // recovery from FAULT counts the first good sample
        step(0, 1, A, 0, 1, 1, 1, 0, 0, 0, 0);
        step(0, 1, A, 0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, A, 0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, A, 0, 2, 1, 1, 0, 0, 0, 0);
        // dead sample faults immediately, good sample restarts locking, clear drops sticky fault
        step(0, 1, 0, 0, 3, 1, 1, 1, 0, 0, H);
        step(0, 1, A, 0, 1, 1, 1, 1, A, 0, H);
        step(0, 0, 0, 1, 1, 0, 0, 1, A, ONES, 0);
        step(0, 1, A, 0, 1, 0, 0, 1, A, A, A);
        step(0, 1, A, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, A, 0, 2, 1, 0, 0, 0, 0, 0);
        // timeout after ten silent cycles, then silent re-entry in FAULT without a pulse
        idle(9, 2, 0);
        step(0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0);
        idle(10, 3, 1);
        step(0, 1, A, 0, 1, 1, 1, 0, 0, 0, 0);
        step(0, 1, A, 0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, A, 0, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, A, 0, 2, 1, 1, 0, 0, 0, 0);
        // a sample on the would-be expiry cycle prevents the timeout
        idle(9, 2, 1);
        step(0, 1, A, 0, 2, 0, 1, 0, 0, 0, 0);
        idle(1, 2, 1);
        // clear with a sample loads extremes; clear coinciding with fault entry keeps fault set
        step(0, 1, 5, 1, 2, 0, 0, 1, 5, 5, 5);
        step(0, 1, 0, 1, 3, 1, 1, 1, 0, 0, 0);
        // reset mid-LOCKING discards the concurrent sample
        step(0, 1, A, 0, 1, 1, 1, 1, A, 0, A);
        step(1, 1, H, 0, 0, 0, 0, 1, 0, ONES, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, ONES, 0);
        step(0, 1, A, 0, 1, 1, 0, 1, A, A, A);
        // inverted window makes any nonzero sample out of range
        bus.i_min = 32'd200;
        bus.i_max = 32'd100;
        step(0, 1, 32'd150, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, A, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 1, A, 32'd150, A);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
